// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - LC-3 multi-cycle control unit
// Sequences fetch/decode/execute and drives all datapath load, enable and select lines.
module lc3_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        mem_rdy,
  output logic        mem_en,
  output logic        mem_we,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic [1:0]  selPC,
  output logic        selMAR,
  output logic        selMDR,
  output logic [1:0]  aluControl,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_ALU_EX, S_BR_EX, S_JMP_EX, S_LEA_EX,
    S_ADDR, S_LD_MEM, S_LD_WB, S_ST_MDR, S_ST_MEM
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  opcode;
  logic        br_taken;
  logic        unused_ir_bits;

  assign opcode         = IR[15:12];
  assign br_taken       = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  // IR[5] (imm vs SR2) is resolved in the datapath; IR[4:3] carry no control meaning.
  assign unused_ir_bits = ^IR[5:3];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    enaALU     = 1'b0;
    enaMARM    = 1'b0;
    enaPC      = 1'b0;
    enaMDR     = 1'b0;
    ldPC       = 1'b0;
    ldIR       = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    regWE      = 1'b0;
    flagWE     = 1'b0;
    selEAB1    = 1'b0;
    selEAB2    = 2'b00;
    selPC      = 2'b00;
    selMAR     = 1'b0;
    selMDR     = 1'b0;
    aluControl = 2'b00;
    SR1        = IR[8:6];
    SR2        = IR[2:0];
    DR         = IR[11:9];
    instr_done = 1'b0;

    case (state_q)
      S_FETCH0: begin
        enaPC   = 1'b1;
        ldMAR   = 1'b1;
        ldPC    = 1'b1;
        state_d = S_FETCH1;
      end
      S_FETCH1: begin
        mem_en = 1'b1;
        selMDR = 1'b1;
        ldMDR  = mem_rdy;
        if (mem_rdy) state_d = S_FETCH2;
      end
      S_FETCH2: begin
        enaMDR  = 1'b1;
        ldIR    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          4'b0001, 4'b0101, 4'b1001: state_d = S_ALU_EX;
          4'b0000:                   state_d = S_BR_EX;
          4'b1100:                   state_d = S_JMP_EX;
          4'b1110:                   state_d = S_LEA_EX;
          4'b0010, 4'b0110,
          4'b0011, 4'b0111:          state_d = S_ADDR;
          default: begin
            instr_done = 1'b1;
            state_d    = S_FETCH0;
          end
        endcase
      end
      S_ALU_EX: begin
        enaALU     = 1'b1;
        regWE      = 1'b1;
        flagWE     = 1'b1;
        aluControl = (opcode == 4'b0001) ? 2'b00 :
                     (opcode == 4'b0101) ? 2'b01 : 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH0;
      end
      S_BR_EX: begin
        if (br_taken) begin
          selEAB2 = 2'b10;
          selPC   = 2'b01;
          ldPC    = 1'b1;
        end
        instr_done = 1'b1;
        state_d    = S_FETCH0;
      end
      S_JMP_EX: begin
        selEAB1    = 1'b1;
        selPC      = 2'b01;
        ldPC       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH0;
      end
      S_LEA_EX: begin
        enaMARM    = 1'b1;
        selEAB2    = 2'b10;
        regWE      = 1'b1;
        flagWE     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH0;
      end
      S_ADDR: begin
        // IR[14] separates base+offset6 (LDR/STR) from PC+offset9 (LD/ST); IR[12] marks stores.
        enaMARM = 1'b1;
        ldMAR   = 1'b1;
        selEAB1 = IR[14];
        selEAB2 = IR[14] ? 2'b01 : 2'b10;
        state_d = IR[12] ? S_ST_MDR : S_LD_MEM;
      end
      S_LD_MEM: begin
        mem_en = 1'b1;
        selMDR = 1'b1;
        ldMDR  = mem_rdy;
        if (mem_rdy) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        enaMDR     = 1'b1;
        regWE      = 1'b1;
        flagWE     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH0;
      end
      S_ST_MDR: begin
        SR1        = IR[11:9];
        enaALU     = 1'b1;
        aluControl = 2'b11;
        ldMDR      = 1'b1;
        state_d    = S_ST_MEM;
      end
      S_ST_MEM: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (mem_rdy) begin
          instr_done = 1'b1;
          state_d    = S_FETCH0;
        end
      end
      default: state_d = S_FETCH0;
    endcase

    if (rst) begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      enaALU     = 1'b0;
      enaMARM    = 1'b0;
      enaPC      = 1'b0;
      enaMDR     = 1'b0;
      ldPC       = 1'b0;
      ldIR       = 1'b0;
      ldMAR      = 1'b0;
      ldMDR      = 1'b0;
      regWE      = 1'b0;
      flagWE     = 1'b0;
      selEAB1    = 1'b0;
      selEAB2    = 2'b00;
      selPC      = 2'b00;
      selMAR     = 1'b0;
      selMDR     = 1'b0;
      aluControl = 2'b00;
      SR1        = 3'b000;
      SR2        = 3'b000;
      DR         = 3'b000;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb/tb_lc3_control_fsm.sv - bench for lc3_control_fsm
// Expected per-cycle output traces are built from the instruction's phase list.
module tb_lc3_control_fsm;

  typedef struct packed {
    logic       mem_en, mem_we, enaALU, enaMARM, enaPC, enaMDR;
    logic       ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE, selEAB1;
    logic [1:0] selEAB2, selPC;
    logic       selMAR, selMDR;
    logic [1:0] aluControl;
    logic [2:0] SR1, SR2, DR;
    logic       instr_done;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR;
  logic        N, Z, P, mem_rdy;
  logic        mem_en, mem_we, enaALU, enaMARM, enaPC, enaMDR;
  logic        ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE, selEAB1;
  logic [1:0]  selEAB2, selPC;
  logic        selMAR, selMDR;
  logic [1:0]  aluControl;
  logic [2:0]  SR1, SR2, DR;
  logic        instr_done;
  outs_t       obs;

  int tests = 0;
  int fails = 0;

  outs_t exp_q[$];
  logic  rdy_q[$];

  always #5 clk = ~clk;

  lc3_control_fsm dut (
    .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .mem_rdy(mem_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .enaALU(enaALU), .enaMARM(enaMARM),
    .enaPC(enaPC), .enaMDR(enaMDR), .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR),
    .ldMDR(ldMDR), .regWE(regWE), .flagWE(flagWE), .selEAB1(selEAB1),
    .selEAB2(selEAB2), .selPC(selPC), .selMAR(selMAR), .selMDR(selMDR),
    .aluControl(aluControl), .SR1(SR1), .SR2(SR2), .DR(DR), .instr_done(instr_done)
  );

  assign obs = {mem_en, mem_we, enaALU, enaMARM, enaPC, enaMDR, ldPC, ldIR, ldMAR,
                ldMDR, regWE, flagWE, selEAB1, selEAB2, selPC, selMAR, selMDR,
                aluControl, SR1, SR2, DR, instr_done};

  function automatic outs_t base(input logic [15:0] ir);
    outs_t o = '0;
    o.SR1 = ir[8:6];
    o.SR2 = ir[2:0];
    o.DR  = ir[11:9];
    return o;
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input outs_t o, input logic rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endtask

  // Memory access of `waits` stalled cycles followed by the completing cycle.
  task automatic push_mem(input outs_t o, input int waits, input logic last_done, input logic read);
    outs_t m = o;
    for (int k = 0; k < waits; k++) push(m, 1'b0);
    if (read) m.ldMDR = 1'b1;
    m.instr_done = last_done;
    push(m, 1'b1);
  endtask

  task automatic build(input logic [15:0] ir, input logic n, input logic z, input logic p,
                       input int fw, input int mw);
    outs_t o;
    logic [3:0] op = ir[15:12];
    exp_q.delete();
    rdy_q.delete();
    o = base(ir); o.enaPC = 1; o.ldMAR = 1; o.ldPC = 1; push(o, rnd_bit());
    o = base(ir); o.mem_en = 1; o.selMDR = 1; push_mem(o, fw, 1'b0, 1'b1);
    o = base(ir); o.enaMDR = 1; o.ldIR = 1; push(o, rnd_bit());
    o = base(ir);
    if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12, 4'd14})) begin
      o.instr_done = 1; push(o, rnd_bit());
      return;
    end
    push(o, rnd_bit());
    o = base(ir);
    case (op)
      4'd1, 4'd5, 4'd9: begin
        o.enaALU = 1; o.regWE = 1; o.flagWE = 1; o.instr_done = 1;
        o.aluControl = (op == 4'd1) ? 2'd0 : (op == 4'd5) ? 2'd1 : 2'd2;
        push(o, rnd_bit());
      end
      4'd0: begin
        if ((ir[11] && n) || (ir[10] && z) || (ir[9] && p)) begin
          o.ldPC = 1; o.selPC = 2'd1; o.selEAB2 = 2'd2;
        end
        o.instr_done = 1; push(o, rnd_bit());
      end
      4'd12: begin
        o.selEAB1 = 1; o.selPC = 2'd1; o.ldPC = 1; o.instr_done = 1; push(o, rnd_bit());
      end
      4'd14: begin
        o.enaMARM = 1; o.selEAB2 = 2'd2; o.regWE = 1; o.flagWE = 1; o.instr_done = 1;
        push(o, rnd_bit());
      end
      default: begin
        o.enaMARM = 1; o.ldMAR = 1;
        o.selEAB1 = (op == 4'd6 || op == 4'd7);
        o.selEAB2 = o.selEAB1 ? 2'd1 : 2'd2;
        push(o, rnd_bit());
        if (op == 4'd2 || op == 4'd6) begin
          o = base(ir); o.mem_en = 1; o.selMDR = 1; push_mem(o, mw, 1'b0, 1'b1);
          o = base(ir); o.enaMDR = 1; o.regWE = 1; o.flagWE = 1; o.instr_done = 1;
          push(o, rnd_bit());
        end else begin
          o = base(ir); o.SR1 = ir[11:9]; o.enaALU = 1; o.aluControl = 2'd3; o.ldMDR = 1;
          push(o, rnd_bit());
          o = base(ir); o.mem_en = 1; o.mem_we = 1; push_mem(o, mw, 1'b1, 1'b0);
        end
      end
    endcase
  endtask

  task automatic check_invariants(input string tag);
    logic ok;
    ok = ($countones({enaALU, enaMARM, enaPC, enaMDR}) <= 1) &&
         (!flagWE || enaALU || enaMDR || enaMARM) && (!mem_we || mem_en);
    tests++;
    assert (ok === 1'b1) else begin
      fails++;
      $error("FAIL inv_%s observed=%h required=invariants_hold", tag, obs);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      mem_rdy = rnd_bit();
      @(negedge clk);
      tests++;
      assert (obs === outs_t'('0)) else begin
        fails++;
        $error("FAIL reset_outs observed=%h required=%h", obs, outs_t'('0));
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic n, input logic z, input logic p,
                           input int fw, input int mw, input int abort_at, input string tag);
    int done_at = 0;
    IR = ir; N = n; Z = z; P = p;
    build(ir, n, z, p, fw, mw);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (abort_at > 0 && i == abort_at) begin
        do_reset(2);
        return;
      end
      mem_rdy = rdy_q[i];
      @(negedge clk);
      tests++;
      assert (obs === exp_q[i]) else begin
        fails++;
        $error("FAIL %s_cyc%0d ir=%h observed=%h required=%h", tag, i, ir, obs, exp_q[i]);
      end
      check_invariants(tag);
      if (instr_done && done_at == 0) done_at = i + 1;
      @(posedge clk); #1;
    end
    tests++;
    assert (done_at === exp_q.size()) else begin
      fails++;
      $error("FAIL %s_len ir=%h observed=%0d required=%0d", tag, ir, done_at, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; IR = '0; N = 0; Z = 0; P = 0; mem_rdy = 0;
    @(posedge clk); #1;
    do_reset(2);

    run_instr(16'h1042, 0, 0, 0, 0, 0, 0, "add");
    run_instr(16'h0403, 0, 1, 0, 0, 0, 0, "brz_taken");
    run_instr(16'h0403, 1, 0, 0, 0, 0, 0, "brz_not");
    run_instr(16'h6283, 0, 0, 0, 0, 3, 0, "ldr_wait");
    run_instr(16'h3605, 0, 0, 0, 0, 0, 0, "st");
    run_instr(16'hD000, 0, 0, 0, 0, 0, 0, "illegal");
    run_instr(16'h5A3F, 0, 0, 1, 2, 0, 0, "and_fwait");
    run_instr(16'h7B41, 0, 0, 0, 1, 2, 0, "str_wait");
    run_instr(16'h6283, 0, 0, 0, 0, 3, 6, "ldr_abort");
    run_instr(16'hC1C0, 0, 0, 0, 0, 0, 0, "jmp_after_rst");

    for (int t = 0; t < 200; t++) begin
      logic [15:0] ir = 16'($urandom);
      int fw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      int mw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      int ab = 0;
      if ($urandom_range(0, 19) == 0) ab = int'($urandom_range(1, 5));
      run_instr(ir, rnd_bit(), rnd_bit(), rnd_bit(), fw, mw, ab, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
